// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit.
// RV32I funct3 width codes and the FSM state encoding.
package lsu_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } lsu_state_e;

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 == SB) || (f3 == SH) || (f3 == SW);
        return (f3 == LB) || (f3 == LH) || (f3 == LW) ||
               (f3 == LBU) || (f3 == LHU);
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Combinational load extractor: lane select plus
// sign/zero extension of the memory read word.
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [31:0] mem_dout,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // pick the addressed lane, then extend by width and sign
    always_comb begin
        byte_sel = mem_dout[{addr, 3'b000} +: 8];
        half_sel = addr[1] ? mem_dout[31:16] : mem_dout[15:0];
        rdata    = '0;
        case (funct3)
            LB:      rdata = {{24{byte_sel[7]}}, byte_sel};
            LH:      rdata = {{16{half_sel[15]}}, half_sel};
            LW:      rdata = mem_dout;
            LBU:     rdata = {24'b0, byte_sel};
            LHU:     rdata = {16'b0, half_sel};
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-request load/store unit: IDLE -> ACCESS -> RESP.
// LSU_MISALIGN_TRAP_EN: misaligned H/W access errors instead of aligning.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_BITS = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic [3:0]  mem_we,
    input  logic [31:0] mem_dout
);

    // a shift by 32 wraps to 0, so the mask is all ones at full width
    localparam logic [31:0] ADDR_MASK = (32'h1 << ADDR_BITS) - 32'h1;

    lsu_state_e  state;
    lsu_state_e  next_state;

    logic        cap_we;
    logic [2:0]  cap_f3;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;

    logic        size_h;
    logic        size_w;
    logic        err;
    logic [31:0] eff_addr;
    logic [3:0]  lane_we;
    logic [31:0] lane_din;
    logic [31:0] ext_rdata;

    assign size_h = (cap_f3[1:0] == 2'b01);
    assign size_w = (cap_f3[1:0] == 2'b10);

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign;
    assign misalign = (size_h && cap_addr[0]) ||
                      (size_w && (cap_addr[1:0] != 2'b00));
    assign eff_addr = cap_addr;
    assign err      = !f3_legal(cap_we, cap_f3) || misalign;
`else
    assign eff_addr = {cap_addr[31:2],
                       size_w ? 2'b00
                              : {cap_addr[1], size_h ? 1'b0 : cap_addr[0]}};
    assign err      = !f3_legal(cap_we, cap_f3);
`endif

    // state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    // next-state: one request per pass, no back-to-back accept
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req_valid) next_state = ACCESS;
            ACCESS:  next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // capture the request on the IDLE handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_we    <= 1'b0;
            cap_f3    <= 3'b000;
            cap_addr  <= '0;
            cap_wdata <= '0;
        end else if (state == IDLE && req_valid) begin
            cap_we    <= req_we;
            cap_f3    <= req_funct3;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
        end
    end

    // store lane enables and replicated write data
    always_comb begin
        lane_we  = 4'b0000;
        lane_din = '0;
        if (cap_we) begin
            case (cap_f3)
                SB: begin
                    lane_we  = 4'b0001 << eff_addr[1:0];
                    lane_din = {4{cap_wdata[7:0]}};
                end
                SH: begin
                    lane_we  = 4'b0011 << eff_addr[1:0];
                    lane_din = {2{cap_wdata[15:0]}};
                end
                SW: begin
                    lane_we  = 4'b1111;
                    lane_din = cap_wdata;
                end
                default: begin
                    lane_we  = 4'b0000;
                    lane_din = '0;
                end
            endcase
        end
    end

    lsu_load_ext u_load_ext (
        .mem_dout (mem_dout),
        .addr     (eff_addr[1:0]),
        .funct3   (cap_f3),
        .rdata    (ext_rdata)
    );

    // rst gates outputs in the same cycle so a write in ACCESS is killed
    assign req_ready  = rst || (state == IDLE);
    assign mem_we     = (state == ACCESS && !rst && !err) ? lane_we : 4'b0000;
    assign mem_din    = rst ? '0 : lane_din;
    assign mem_addr   = rst ? '0 : (eff_addr & ADDR_MASK);
    assign resp_valid = (state == RESP) && !rst;
    assign resp_err   = resp_valid && err;
    assign resp_rdata = (resp_valid && !cap_we && !err) ? ext_rdata : '0;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_BITS, default 12, meaning: number of low address bits forwarded to memory; mem_addr bits above it SHALL be 0.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset: synchronous, active-high.
REQ-004 req_valid  input  1  core presents a memory request.
REQ-005 req_ready  output  1  unit can accept a request this cycle.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32I width/sign code.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, LSB-justified.
REQ-010 resp_valid  output  1  one-cycle completion pulse.
REQ-011 resp_rdata  output  32  load result, extended to 32 bits.
REQ-012 resp_err  output  1  request rejected: misaligned or illegal funct3.
REQ-013 mem_addr  output  32  address to the word-addressed data memory.
REQ-014 mem_din  output  32  lane-replicated store data.
REQ-015 mem_we  output  4  per-byte write enables.
REQ-016 mem_dout  input  32  memory read word, valid the cycle after the address edge.

Function
REQ-017 FSM states SHALL be IDLE, ACCESS and RESP; req_ready SHALL be 1 only in IDLE.
REQ-018 Handshake: req_valid and req_ready high at a rising edge SHALL capture we, funct3, addr and wdata, then go IDLE to ACCESS.
REQ-019 ACCESS SHALL drive mem_addr from the captured address, assert mem_we per REQ-021, and go to RESP on the next edge.
REQ-020 RESP SHALL assert resp_valid for exactly one cycle, then return to IDLE; resp_valid SHALL therefore be high in the second cycle after acceptance.
REQ-021 Store lanes: SB gives mem_we = 0001 << addr[1:0] and mem_din = {4{wdata[7:0]}}; SH gives mem_we = 0011 << addr[1:0] and mem_din = {2{wdata[15:0]}}; SW gives mem_we = 1111 and mem_din = wdata.
REQ-022 Load extraction in RESP: select the byte or halfword of mem_dout at addr[1:0]; LB and LH sign-extend, LBU and LHU zero-extend, LW passes through.
REQ-023 Legal funct3: loads 000, 001, 010, 100, 101; stores 000, 001, 010; any other code SHALL produce resp_err = 1.
REQ-024 mem_we SHALL be 0000 in every state except ACCESS, and also in ACCESS for loads and erroneous requests.
REQ-025 On an error response, resp_rdata SHALL be 0 and the memory SHALL NOT be written.
REQ-026 resp_rdata and resp_err SHALL be 0 whenever resp_valid is 0.
REQ-027 For a store response, resp_rdata SHALL be 0.
REQ-028 A request held on req_valid during ACCESS or RESP SHALL be ignored until IDLE; there is no back-to-back acceptance.

Reset
REQ-029 rst high at an edge SHALL force IDLE and clear all captured registers, in any state.
REQ-030 During and after reset: req_ready = 1, resp_valid = 0, resp_err = 0, resp_rdata = 0, mem_we = 0000, mem_addr = 0, mem_din = 0.
REQ-031 Reset asserted during ACCESS SHALL suppress the write at that edge (mem_we = 0000 from that cycle) and SHALL suppress the pending response.

Configuration
REQ-032 Macro LSU_MISALIGN_TRAP_EN defined: a halfword with addr[0] = 1, or a word with addr[1:0] != 00, SHALL return resp_err = 1 per REQ-025.
REQ-033 Macro LSU_MISALIGN_TRAP_EN undefined: the unit SHALL force addr[0] to 0 for halfwords and addr[1:0] to 00 for words, and complete normally; misalignment SHALL never set resp_err (illegal funct3 still does).

Structure
REQ-034 Package lsu_pkg SHALL hold the funct3 constants (LB/LH/LW/LBU/LHU, SB/SH/SW) and the FSM state typedef.
REQ-035 Sub-module lsu_load_ext SHALL be the purely combinational load extractor (mem_dout, addr[1:0], funct3 to rdata), instantiated once.

Verification
REQ-036 SW addr 0x10, wdata 0xDEADBEEF -> in ACCESS mem_we = 1111, mem_din = 0xDEADBEEF; resp_valid 2 cycles after accept, resp_err = 0.
REQ-037 SB addr 0x13, wdata 0x000000A5 -> mem_we = 1000, mem_din = 0xA5A5A5A5.
REQ-038 LB addr 0x13 with mem_dout = 0x80FF0000 -> resp_rdata = 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x12 -> 0x000080FF.
REQ-039 LW addr 0x0A with LSU_MISALIGN_TRAP_EN -> resp_err = 1, rdata = 0, no mem_we; without it -> mem_addr[1:0] = 00, normal response.
REQ-040 Store accepted, then rst high in ACCESS -> mem_we = 0000 at that edge, no resp_valid, req_ready = 1 the next cycle.
REQ-041 funct3 = 011 load, then req_valid held high through RESP -> one error response, second request accepted only in IDLE.
